ucca_violation_handler: RTL

- Receiving end of the UCCA region's violation outputs.
- Takes the per-monitor reset requests (return integrity, stack protection) and drives the core reset request for a fixed hold window.
- Records cause, violation PC and a saturating violation count in sticky registers that survive UCCA-triggered resets.
- Exposes those registers read-only (status is write-1-to-clear) on the peripheral data bus so software can diagnose after reboot.

---
 rtl/ucca_violation_handler_pkg.sv | 30 +++
 rtl/ucca_violation_handler_if.sv | 11 +
 rtl/ucca_violation_regs.sv | 63 ++++++
 rtl/ucca_violation_handler.sv | 81 ++++++++
 4 files changed

// File: rtl/ucca_violation_handler_pkg.sv
// Shared types and constants for the UCCA violation handler: FSM encoding,
// register offsets and STATUS bit positions.
package ucca_violation_handler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] OFF_STATUS = 16'd0;
  localparam logic [15:0] OFF_VPC    = 16'd2;
  localparam logic [15:0] OFF_VCOUNT = 16'd4;

  localparam int BIT_RET = 0;
  localparam int BIT_STK = 1;
  localparam int BIT_OVF = 15;

  localparam logic [15:0] STATUS_MASK = 16'h8003;

  // Word-aligned match: bit 0 of the byte address is ignored.
  function automatic logic addr_hit(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] off);
    logic [15:0] target;
    target = base + off;
    return addr[15:1] == target[15:1];
  endfunction

endpackage

// File: rtl/ucca_violation_handler_if.sv
// Peripheral data bus between the core and the violation handler registers.
interface ucca_violation_handler_if;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [15:0] data_in;
  logic [15:0] data_out;

  modport master (output data_en, data_wr, data_addr, data_in, input data_out);
  modport slave  (input data_en, data_wr, data_addr, data_in, output data_out);
endinterface

// File: rtl/ucca_violation_regs.sv
// Sticky diagnostic registers (STATUS, VPC, VCOUNT) with W1C status bits
// and a registered read mux; cleared only by system_reset.
module ucca_violation_regs
  import ucca_violation_handler_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0170
) (
  input  logic                     clk,
  input  logic                     system_reset,
  ucca_violation_handler_if.slave  bus,
  input  logic                     set_en,
  input  logic                     set_ret,
  input  logic                     set_stk,
  input  logic                     capture,
  input  logic [15:0]              pc
);

  logic [15:0] status_q, vpc_q, vcount_q;
  logic [15:0] status_set, status_clr, status_d;
  logic [15:0] rdata_d;
  logic        sel_status, sel_vpc, sel_vcount;
  logic        count_full;

  always_comb begin
    sel_status = bus.data_en & addr_hit(bus.data_addr, BASE_ADDR, OFF_STATUS);
    sel_vpc    = bus.data_en & addr_hit(bus.data_addr, BASE_ADDR, OFF_VPC);
    sel_vcount = bus.data_en & addr_hit(bus.data_addr, BASE_ADDR, OFF_VCOUNT);
    count_full = (vcount_q == 16'hFFFF);

    status_set          = '0;
    status_set[BIT_RET] = set_en & set_ret;
    status_set[BIT_STK] = set_en & set_stk;
    status_set[BIT_OVF] = capture & count_full;

    status_clr = (sel_status & bus.data_wr) ? (bus.data_in & STATUS_MASK) : '0;
    // Clear first, then set, so a same-cycle hardware event is never lost.
    status_d   = (status_q & ~status_clr) | status_set;

    rdata_d = '0;
    if (!bus.data_wr) begin
      if (sel_status)      rdata_d = status_q;
      else if (sel_vpc)    rdata_d = vpc_q;
      else if (sel_vcount) rdata_d = vcount_q;
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      status_q     <= '0;
      vpc_q        <= '0;
      vcount_q     <= '0;
      bus.data_out <= '0;
    end else begin
      status_q     <= status_d;
      bus.data_out <= rdata_d;
      if (capture) begin
        vpc_q <= pc;
        if (!count_full) vcount_q <= vcount_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ucca_violation_handler.sv
// Turns UCCA monitor reset requests into a fixed-length core reset pulse and
// feeds the sticky diagnostic registers.
module ucca_violation_handler
  import ucca_violation_handler_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0170,
  parameter int          HOLD_CYCLES = 8,
  parameter int          CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     system_reset,
  input  logic                     return_reset,
  input  logic                     stack_reset,
  input  logic [15:0]              pc,
  ucca_violation_handler_if.slave  bus,
  output logic                     reset_out
);

  // state | meaning
  // IDLE  | armed, waiting for a violation request
  // HOLD  | driving reset_out, counter runs HOLD_CYCLES-1 down to 0
  // DRAIN | pulse done, waiting for every request to drop before re-arming

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             viol, capture, set_en;

  assign viol = return_reset | stack_reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    set_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (viol) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_LOAD;
          capture = 1'b1;
          set_en  = 1'b1;
        end
      end
      ST_HOLD: begin
        set_en = 1'b1;
        if (cnt_q == '0) state_d = ST_DRAIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DRAIN: begin
        if (!viol) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      reset_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reset_out <= (state_d == ST_HOLD);
    end
  end

  ucca_violation_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk          (clk),
    .system_reset (system_reset),
    .bus          (bus),
    .set_en       (set_en),
    .set_ret      (return_reset),
    .set_stk      (stack_reset),
    .capture      (capture),
    .pc           (pc)
  );

endmodule
